// File: rtl/swalloc.sv
// Switch allocator for the 5x5 router.
// Each output port is shared round-robin among the inputs whose route
// computation selected it. A grant of a head flit locks the output to that
// input (wormhole) until the tail flit transfers. Drives the crossbar selects.
module swalloc #(
   parameter int NPORT = 5,
   parameter int PORTW = 3
) (
   input  logic                   clk,
   input  logic                   rst_,
   input  logic [NPORT-1:0]       req,
   input  logic [NPORT*PORTW-1:0] req_port,
   input  logic [NPORT-1:0]       tail,
   input  logic [NPORT-1:0]       oready,
   output logic [NPORT-1:0]       grant,
   output logic [NPORT*PORTW-1:0] osel,
   output logic [NPORT-1:0]       ovalid,
   output logic [NPORT-1:0]       obusy
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } lock_t;

   // Registered per-output state: lock, owning input, round-robin pointer.
   lock_t            r_lock  [NPORT];
   logic [PORTW-1:0] r_owner [NPORT];
   logic [PORTW-1:0] r_ptr   [NPORT];

   // Next-state values.
   lock_t            w_lockNext  [NPORT];
   logic [PORTW-1:0] w_ownerNext [NPORT];
   logic [PORTW-1:0] w_ptrNext   [NPORT];

   // Arbitration helpers.
   logic [NPORT-1:0] w_owned;
   logic [NPORT-1:0] w_cand    [NPORT];
   logic [NPORT-1:0] w_pickValid;
   logic [PORTW-1:0] w_pickIdx [NPORT];

   // Inputs that currently hold a lock on some output are kept out of every
   // candidate set, so an input can never be allocated a second output.
   always_comb begin
      w_owned = '0;
      for (int o = 0; o < NPORT; o++) begin
         for (int i = 0; i < NPORT; i++) begin
            if (r_lock[o] == ST_BUSY && r_owner[o] == PORTW'(i)) begin
               w_owned[i] = 1'b1;
            end
         end
      end
   end

   // Candidate matrix: input i competes for output o when it requests o.
   // A requested port value >= NPORT matches no output.
   always_comb begin
      for (int o = 0; o < NPORT; o++) begin
         w_cand[o] = '0;
         for (int i = 0; i < NPORT; i++) begin
            w_cand[o][i] = req[i] && !w_owned[i] &&
                           (req_port[i*PORTW +: PORTW] == PORTW'(o));
         end
      end
   end

   // Round-robin search per output, starting at its pointer and wrapping.
   always_comb begin
      for (int o = 0; o < NPORT; o++) begin
         w_pickValid[o] = 1'b0;
         w_pickIdx[o]   = '0;
         for (int k = 0; k < NPORT; k++) begin
            int j;
            j = (int'(r_ptr[o]) + k) % NPORT;
            if (!w_pickValid[o] && w_cand[o][j]) begin
               w_pickValid[o] = 1'b1;
               w_pickIdx[o]   = PORTW'(j);
            end
         end
      end
   end

   // Output decode: a locked output forwards its owner's flit whenever the
   // owner has one and downstream is ready; idle outputs drive select 0.
   always_comb begin
      grant  = '0;
      ovalid = '0;
      osel   = '0;
      obusy  = '0;
      for (int o = 0; o < NPORT; o++) begin
         if (r_lock[o] == ST_BUSY) begin
            obusy[o]                  = 1'b1;
            osel[o*PORTW +: PORTW]    = r_owner[o];
            if (req[r_owner[o]] && oready[o]) begin
               ovalid[o]           = 1'b1;
               grant[r_owner[o]]   = 1'b1;
            end
         end
      end
   end

   // Lock FSM per output: allocate on an idle cycle with candidates (no
   // grant that cycle), release when the owner's tail flit transfers.
   always_comb begin
      for (int o = 0; o < NPORT; o++) begin
         w_lockNext[o]  = r_lock[o];
         w_ownerNext[o] = r_owner[o];
         w_ptrNext[o]   = r_ptr[o];
         case (r_lock[o])
            ST_IDLE: begin
               if (w_pickValid[o]) begin
                  w_lockNext[o]  = ST_BUSY;
                  w_ownerNext[o] = w_pickIdx[o];
                  w_ptrNext[o]   = (w_pickIdx[o] == PORTW'(NPORT-1)) ?
                                   '0 : w_pickIdx[o] + 1'b1;
               end
            end
            ST_BUSY: begin
               if (ovalid[o] && tail[r_owner[o]]) begin
                  w_lockNext[o] = ST_IDLE;
               end
            end
            default: begin
               w_lockNext[o] = ST_IDLE;
            end
         endcase
      end
   end

   // State registers; reset drops every lock and rewinds the pointers.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         for (int o = 0; o < NPORT; o++) begin
            r_lock[o]  <= ST_IDLE;
            r_owner[o] <= '0;
            r_ptr[o]   <= '0;
         end
      end else begin
         for (int o = 0; o < NPORT; o++) begin
            r_lock[o]  <= w_lockNext[o];
            r_owner[o] <= w_ownerNext[o];
            r_ptr[o]   <= w_ptrNext[o];
         end
      end
   end

endmodule

// File: tb/tb_swalloc.sv
// Directed testbench for the switch allocator.
module tb_swalloc;

   localparam int NPORT = 5;
   localparam int PORTW = 3;

   logic                   clk;
   logic                   rst_;
   logic [NPORT-1:0]       req;
   logic [NPORT*PORTW-1:0] req_port;
   logic [NPORT-1:0]       tail;
   logic [NPORT-1:0]       oready;
   logic [NPORT-1:0]       grant;
   logic [NPORT*PORTW-1:0] osel;
   logic [NPORT-1:0]       ovalid;
   logic [NPORT-1:0]       obusy;

   int testCount;
   int failCount;

   swalloc #(.NPORT(NPORT), .PORTW(PORTW)) dut (
      .clk      (clk),
      .rst_     (rst_),
      .req      (req),
      .req_port (req_port),
      .tail     (tail),
      .oready   (oready),
      .grant    (grant),
      .osel     (osel),
      .ovalid   (ovalid),
      .obusy    (obusy)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [NPORT*PORTW-1:0] portVec(input int p0, p1, p2, p3, p4);
      return {PORTW'(p4), PORTW'(p3), PORTW'(p2), PORTW'(p1), PORTW'(p0)};
   endfunction

   function automatic logic [31:0] oselOf(input int o);
      return 32'(osel[o*PORTW +: PORTW]);
   endfunction

   // Advance to just after the next rising edge, drive the cycle's inputs,
   // then let the combinational outputs settle.
   task automatic applyStimulus(input logic [NPORT-1:0] r,
                                input logic [NPORT*PORTW-1:0] p,
                                input logic [NPORT-1:0] t,
                                input logic [NPORT-1:0] rdy);
      @(posedge clk);
      #1;
      req      = r;
      req_port = p;
      tail     = t;
      oready   = rdy;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      testCount = 0;
      failCount = 0;
      rst_      = 1'b0;
      req       = '0;
      req_port  = '0;
      tail      = '0;
      oready    = '1;

      // Reset state
      #3;
      checkOutput("rst_grant",  32'(grant),  32'h0);
      checkOutput("rst_ovalid", 32'(ovalid), 32'h0);
      checkOutput("rst_obusy",  32'(obusy),  32'h0);
      checkOutput("rst_osel",   32'(osel),   32'h0);
      @(posedge clk);
      #1;
      rst_ = 1'b1;

      // 1: single-flit packet input 0 -> port 1
      applyStimulus(5'b00001, portVec(1,0,0,0,0), 5'b00001, 5'b11111);
      checkOutput("t1_alloc_grant", 32'(grant), 32'h0);
      checkOutput("t1_alloc_obusy", 32'(obusy), 32'h0);
      applyStimulus(5'b00001, portVec(1,0,0,0,0), 5'b00001, 5'b11111);
      checkOutput("t1_grant",  32'(grant),  32'b00001);
      checkOutput("t1_osel1",  oselOf(1),   32'd0);
      checkOutput("t1_ovalid", 32'(ovalid), 32'b00010);
      checkOutput("t1_obusy",  32'(obusy),  32'b00010);
      applyStimulus(5'b00000, portVec(0,0,0,0,0), 5'b00000, 5'b11111);
      checkOutput("t1_release", 32'(obusy), 32'h0);

      // 2: inputs 0, 2, 3 -> port 4, round robin from ptr 0
      applyStimulus(5'b01101, portVec(4,0,4,4,0), 5'b11111, 5'b11111);
      checkOutput("t2_alloc0", 32'(grant), 32'h0);
      applyStimulus(5'b01101, portVec(4,0,4,4,0), 5'b11111, 5'b11111);
      checkOutput("t2_grant0",  32'(grant),  32'b00001);
      checkOutput("t2_ovalid0", 32'(ovalid), 32'b10000);
      checkOutput("t2_osel0",   oselOf(4),   32'd0);
      applyStimulus(5'b01100, portVec(4,0,4,4,0), 5'b11111, 5'b11111);
      checkOutput("t2_bubble0", 32'(grant), 32'h0);
      applyStimulus(5'b01100, portVec(4,0,4,4,0), 5'b11111, 5'b11111);
      checkOutput("t2_grant2", 32'(grant), 32'b00100);
      checkOutput("t2_osel2",  oselOf(4),  32'd2);
      applyStimulus(5'b01000, portVec(4,0,4,4,0), 5'b11111, 5'b11111);
      checkOutput("t2_bubble2", 32'(grant), 32'h0);
      applyStimulus(5'b01000, portVec(4,0,4,4,0), 5'b11111, 5'b11111);
      checkOutput("t2_grant3", 32'(grant), 32'b01000);
      // ptr[4] is now 4: input 4 beats input 0
      applyStimulus(5'b10001, portVec(4,0,0,0,4), 5'b11111, 5'b11111);
      checkOutput("t2_alloc_ptr4", 32'(grant), 32'h0);
      applyStimulus(5'b10001, portVec(4,0,0,0,4), 5'b11111, 5'b11111);
      checkOutput("t2_grant_ptr4", 32'(grant), 32'b10000);
      checkOutput("t2_osel_ptr4",  oselOf(4),  32'd4);
      applyStimulus(5'b00000, portVec(0,0,0,0,0), 5'b00000, 5'b11111);

      // 3: input 1 sends 4 flits to port 2 while input 4 waits for port 2
      applyStimulus(5'b10010, portVec(0,2,0,0,2), 5'b10000, 5'b11111);
      checkOutput("t3_alloc", 32'(grant), 32'h0);
      for (int f = 0; f < 3; f++) begin
         applyStimulus(5'b10010, portVec(0,2,0,0,2), 5'b10000, 5'b11111);
         checkOutput($sformatf("t3_body%0d", f), 32'(grant), 32'b00010);
      end
      checkOutput("t3_osel",   oselOf(2),   32'd1);
      checkOutput("t3_ovalid", 32'(ovalid), 32'b00100);
      applyStimulus(5'b10010, portVec(0,2,0,0,2), 5'b10010, 5'b11111);
      checkOutput("t3_tail", 32'(grant), 32'b00010);
      applyStimulus(5'b10000, portVec(0,2,0,0,2), 5'b10000, 5'b11111);
      checkOutput("t3_bubble",       32'(grant), 32'h0);
      checkOutput("t3_bubble_obusy", 32'(obusy), 32'h0);
      applyStimulus(5'b10000, portVec(0,2,0,0,2), 5'b10000, 5'b11111);
      checkOutput("t3_grant4", 32'(grant), 32'b10000);
      checkOutput("t3_osel4",  oselOf(2),  32'd4);
      applyStimulus(5'b00000, portVec(0,0,0,0,0), 5'b00000, 5'b11111);

      // 4: output 0 stalled by oready[0]=0 for 3 cycles
      applyStimulus(5'b01000, portVec(0,0,0,0,0), 5'b00000, 5'b11111);
      checkOutput("t4_alloc", 32'(grant), 32'h0);
      applyStimulus(5'b01000, portVec(0,0,0,0,0), 5'b00000, 5'b11111);
      checkOutput("t4_head",   32'(grant),  32'b01000);
      checkOutput("t4_ovalid", 32'(ovalid), 32'b00001);
      for (int s = 0; s < 3; s++) begin
         applyStimulus(5'b01000, portVec(0,0,0,0,0), 5'b00000, 5'b11110);
         checkOutput($sformatf("t4_stall_grant%0d", s),  32'(grant),  32'h0);
         checkOutput($sformatf("t4_stall_ovalid%0d", s), 32'(ovalid), 32'h0);
         checkOutput($sformatf("t4_stall_obusy%0d", s),  32'(obusy),  32'b00001);
         checkOutput($sformatf("t4_stall_osel%0d", s),   oselOf(0),   32'd3);
      end
      applyStimulus(5'b01000, portVec(0,0,0,0,0), 5'b00000, 5'b11111);
      checkOutput("t4_resume", 32'(grant), 32'b01000);
      applyStimulus(5'b01000, portVec(0,0,0,0,0), 5'b01000, 5'b11111);
      checkOutput("t4_tail", 32'(grant), 32'b01000);
      applyStimulus(5'b00000, portVec(0,0,0,0,0), 5'b00000, 5'b11111);
      checkOutput("t4_release", 32'(obusy), 32'h0);

      // 5: full permutation, all five grants together
      applyStimulus(5'b11111, portVec(1,2,3,4,0), 5'b11111, 5'b11111);
      checkOutput("t5_alloc", 32'(grant), 32'h0);
      applyStimulus(5'b11111, portVec(1,2,3,4,0), 5'b11111, 5'b11111);
      checkOutput("t5_grant",  32'(grant),  32'b11111);
      checkOutput("t5_ovalid", 32'(ovalid), 32'b11111);
      checkOutput("t5_osel",   32'(osel),   32'({3'd3, 3'd2, 3'd1, 3'd0, 3'd4}));
      applyStimulus(5'b00000, portVec(0,0,0,0,0), 5'b00000, 5'b11111);
      checkOutput("t5_release", 32'(obusy), 32'h0);

      // 6: asynchronous reset mid-packet; ptr[3] is 2 before the reset
      applyStimulus(5'b00110, portVec(0,3,3,0,0), 5'b00000, 5'b11111);
      checkOutput("t6_alloc", 32'(grant), 32'h0);
      applyStimulus(5'b00110, portVec(0,3,3,0,0), 5'b00000, 5'b11111);
      checkOutput("t6_grant1", 32'(grant), 32'b00010);
      checkOutput("t6_obusy",  32'(obusy), 32'b01000);
      #2;
      rst_ = 1'b0;
      #1;
      checkOutput("t6_async_obusy",  32'(obusy),  32'h0);
      checkOutput("t6_async_grant",  32'(grant),  32'h0);
      checkOutput("t6_async_ovalid", 32'(ovalid), 32'h0);
      checkOutput("t6_async_osel",   32'(osel),   32'h0);
      @(posedge clk);
      #1;
      rst_ = 1'b1;
      #1;
      checkOutput("t6_realloc_cycle", 32'(grant), 32'h0);
      applyStimulus(5'b00110, portVec(0,3,3,0,0), 5'b00000, 5'b11111);
      checkOutput("t6_ptr0_grant", 32'(grant), 32'b00010);
      checkOutput("t6_ptr0_osel",  oselOf(3),  32'd1);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
